wb_intercon_n: RTL and testbench
================================

// Module: wb_intercon_n
// PURPOSE
//  Parametrised Wishbone shared-bus interconnect: one master, NSLAVES slaves, mask/match decode.
//  Registers the decoded slave, gates cyc/stb per slave and muxes ack/data back to the master.
//  Adds bus-error return for unmapped addresses and a watchdog timeout for dead slaves.
//  Sits between the moxie core's bus master and the memory/peripheral slaves.
// PARAMETERS
//  NSLAVES    4                    number of slave ports (1..16)
//  ADDR_W     32                   address width
//  DATA_W     32                   data width
//  SEL_W      DATA_W/8             byte-select width
//  SLAVE_MASK {NSLAVES*ADDR_W{1'b0}} packed masks, slave k at [k*ADDR_W +: ADDR_W]
//  SLAVE_ADDR {NSLAVES*ADDR_W{1'b0}} packed match values, same packing
//  TIMEOUT    255                  max ACTIVE cycles without ack before error; 0 = watchdog off
// PORTS
//  clk_i      in   1               system clock, all state on rising edge
//  rst_i      in   1               synchronous, active-high reset
//  wbm_adr_i  in   ADDR_W          master address
//  wbm_dat_i  in   DATA_W          master write data
//  wbm_sel_i  in   SEL_W           master byte selects
//  wbm_we_i   in   1               master write enable
//  wbm_cyc_i  in   1               master cycle
//  wbm_stb_i  in   1               master strobe
//  wbm_dat_o  out  DATA_W          read data from selected slave
//  wbm_ack_o  out  1               ack from selected slave
//  wbm_err_o  out  1               bus error (unmapped address or timeout)
//  wbs_adr_o  out  ADDR_W          broadcast address (shared by all slaves)
//  wbs_dat_o  out  DATA_W          broadcast write data
//  wbs_sel_o  out  SEL_W           broadcast byte selects
//  wbs_we_o   out  1               broadcast write enable
//  wbs_cyc_o  out  NSLAVES         per-slave cycle, one-hot or zero
//  wbs_stb_o  out  NSLAVES         per-slave strobe, one-hot or zero
//  wbs_dat_i  in   NSLAVES*DATA_W  packed slave read data
//  wbs_ack_i  in   NSLAVES         per-slave ack
// BEHAVIOUR
//  Reset: state=IDLE, sel_q=0, cnt=0, err=0.
//   -> wbs_cyc_o=0, wbs_stb_o=0, wbm_ack_o=0, wbm_err_o=0, wbm_dat_o=0.
//  Broadcast: wbs_adr/dat/sel/we_o = master inputs, combinational, in every state.
//  Decode: hit[k] = ((wbm_adr_i & MASK[k]) == ADDR[k]). Lowest k wins on multiple hits.
//  FSM IDLE:
//   - cyc_i&stb_i and any hit: sel_q <= onehot(lowest hit), cnt <= 0, -> ACTIVE.
//   - cyc_i&stb_i and no hit: -> ERR.
//   - otherwise stay IDLE.
//   - No slave strobes in IDLE, so slave stb lags master stb by exactly 1 cycle.
//  FSM ACTIVE:
//   - wbs_cyc_o = sel_q & {NSLAVES{wbm_cyc_i}}; wbs_stb_o = sel_q & {NSLAVES{wbm_stb_i}}.
//   - wbm_ack_o = |(wbs_ack_i & sel_q), combinational. Acks from unselected slaves are ignored.
//   - wbm_dat_o = data of the sel_q slave. It is 0 whenever sel_q == 0.
//   - Ack seen: -> IDLE, sel_q <= 0. Back-to-back requests re-decode from IDLE.
//   - Master drops cyc_i (abort): -> IDLE, sel_q <= 0. Slave cyc/stb fall in that same cycle.
//   - Otherwise cnt <= cnt+1, saturating; cnt width = $clog2(TIMEOUT+1).
//   - TIMEOUT != 0 and cnt == TIMEOUT-1 with no ack: -> ERR, sel_q <= 0.
//   - Ack on the timeout cycle wins: no ERR.
//  FSM ERR: wbm_err_o=1 for exactly one cycle, wbm_ack_o=0, all slave cyc/stb=0; -> IDLE.
//  wbm_ack_o and wbm_err_o are never both 1.
//  rst_i mid-cycle: state clears at that edge; slave cyc/stb are 0 from the next cycle; no ack/err issued.
// TESTING
//  1) MASK0=F000_0000 ADDR0=0; read 0000_0010; slave0 acks 2 cycles later with DEAD_BEEF.
//     -> stb0 rises 1 cycle after stb_i; wbm_ack_o=1 with wbm_dat_o=DEAD_BEEF; stb1..3 stay 0.
//  2) Slaves 1 and 2 both match 4000_0000 -> only wbs_stb_o[1] asserts.
//  3) Access to an unmapped address -> wbm_err_o=1 for 1 cycle, 1 cycle after stb_i; no slave stb.
//  4) TIMEOUT=4, selected slave never acks -> err 4 ACTIVE cycles after entry; slave stb drops.
//  5) Slave 3 asserts ack while slave 0 is selected -> wbm_ack_o stays 0; transfer completes on ack0.
//  6) rst_i in the 2nd ACTIVE cycle -> next cycle all wbs_cyc_o/stb_o=0, ack=err=0, FSM=IDLE.
//  7) Master drops cyc_i mid-ACTIVE -> slave cyc/stb fall the same cycle; next request decodes normally.

Source files
------------

// File: rtl/wb_intercon_n.sv
// ---------------------------------------------------------------------------
// wb_intercon_n
// Shared-bus Wishbone interconnect: one master, NSLAVES slaves.
//
// The master address is decoded against per-slave mask/match pairs. The
// lowest-numbered matching slave is latched into a one-hot select register.
// cyc/stb are then gated to that slave only, and its ack/read data are
// returned to the master. Unmapped addresses return a one-cycle bus error.
// A watchdog converts a silent slave into a bus error after TIMEOUT cycles.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   wbm_*_i/_o      master side (adr, dat, sel, we, cyc, stb in;
//                   dat, ack, err out)
//   wbs_adr/dat/sel/we_o
//                   address, write data, byte selects and write enable,
//                   broadcast to every slave
//   wbs_cyc/stb_o   per-slave cycle/strobe, one-hot or zero
//   wbs_dat_i       packed slave read data, slave k at [k*DATA_W +: DATA_W]
//   wbs_ack_i       per-slave ack
// ---------------------------------------------------------------------------
module wb_intercon_n #(
  parameter int                        NSLAVES    = 4,
  parameter int                        ADDR_W     = 32,
  parameter int                        DATA_W     = 32,
  parameter int                        SEL_W      = DATA_W / 8,
  parameter logic [NSLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter logic [NSLAVES*ADDR_W-1:0] SLAVE_ADDR = '0,
  parameter int                        TIMEOUT    = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_W-1:0]         wbm_adr_i,
  input  logic [DATA_W-1:0]         wbm_dat_i,
  input  logic [SEL_W-1:0]          wbm_sel_i,
  input  logic                      wbm_we_i,
  input  logic                      wbm_cyc_i,
  input  logic                      wbm_stb_i,
  output logic [DATA_W-1:0]         wbm_dat_o,
  output logic                      wbm_ack_o,
  output logic                      wbm_err_o,
  output logic [ADDR_W-1:0]         wbs_adr_o,
  output logic [DATA_W-1:0]         wbs_dat_o,
  output logic [SEL_W-1:0]          wbs_sel_o,
  output logic                      wbs_we_o,
  output logic [NSLAVES-1:0]        wbs_cyc_o,
  output logic [NSLAVES-1:0]        wbs_stb_o,
  input  logic [NSLAVES*DATA_W-1:0] wbs_dat_i,
  input  logic [NSLAVES-1:0]        wbs_ack_i
);

  // A watchdog-off build still needs a 1-bit counter to keep widths legal.
  localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERR
  } state_t;

  state_t              state_q, state_d;
  logic [NSLAVES-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NSLAVES-1:0]  hit;
  logic [NSLAVES-1:0]  hit_lowest;
  logic                ack_sel;
  logic [DATA_W-1:0]   rdata_sel;

  // Request fields go to every slave unconditionally; only cyc/stb select.
  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_sel_o = wbm_sel_i;
  assign wbs_we_o  = wbm_we_i;

  // Address decode against every mask/match pair.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      hit[k] = ((wbm_adr_i & SLAVE_MASK[k*ADDR_W +: ADDR_W]) ==
                SLAVE_ADDR[k*ADDR_W +: ADDR_W]);
    end
  end

  // x & -x isolates the lowest set bit, so the lowest-numbered slave wins
  // on overlapping windows.
  assign hit_lowest = hit & (~hit + NSLAVES'(1));

  // Return path. sel_q is one-hot or zero, so an AND-OR mux is enough, and
  // it yields zero data when nothing is selected.
  assign ack_sel = |(wbs_ack_i & sel_q);

  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (sel_q[k]) begin
        rdata_sel = rdata_sel | wbs_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // State, select and watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and all master/slave handshake outputs.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_dat_o = '0;

    case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (|hit) begin
            sel_d   = hit_lowest;
            cnt_d   = '0;
            state_d = ACTIVE;
          end else begin
            state_d = ERR;
          end
        end
      end

      ACTIVE: begin
        wbs_cyc_o = sel_q & {NSLAVES{wbm_cyc_i}};
        wbs_stb_o = sel_q & {NSLAVES{wbm_stb_i}};
        wbm_ack_o = ack_sel;
        wbm_dat_o = rdata_sel;
        // An ack or a master abort ends the transfer. An ack on the
        // timeout cycle therefore takes priority over the watchdog.
        if (ack_sel || !wbm_cyc_i) begin
          sel_d   = '0;
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          sel_d   = '0;
          state_d = ERR;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ERR: begin
        wbm_err_o = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_intercon_n.sv
// ---------------------------------------------------------------------------
// tb_wb_intercon_n
// Self-checking bench for wb_intercon_n with four slaves and TIMEOUT=4.
//
// Address map:
//   slave 0: 0xxx_xxxx
//   slave 1: 4xxx_xxxx
//   slave 2: 4xxx_xxxx / 5xxx_xxxx (overlaps slave 1)
//   slave 3: 8xxx_xxxx
//
// Each transaction is described by its address, its ack delay, any stray ack
// from another slave, and an optional abort or reset point. The expected
// waveform is derived from the address map and those transaction rules.
// ---------------------------------------------------------------------------
module tb_wb_intercon_n;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  localparam logic [NS*AW-1:0] MASKS = {32'hF000_0000, 32'hE000_0000,
                                        32'hF000_0000, 32'hF000_0000};
  localparam logic [NS*AW-1:0] ADDRS = {32'h8000_0000, 32'h4000_0000,
                                        32'h4000_0000, 32'h0000_0000};

  // Reference copy of the address map, index 0 = slave 0.
  logic [31:0] mask_tab [NS] = '{32'hF000_0000, 32'hF000_0000,
                                 32'hE000_0000, 32'hF000_0000};
  logic [31:0] addr_tab [NS] = '{32'h0000_0000, 32'h4000_0000,
                                 32'h4000_0000, 32'h8000_0000};

  logic             clk;
  logic             rst;
  logic [AW-1:0]    wbm_adr;
  logic [DW-1:0]    wbm_dat_w;
  logic [SW-1:0]    wbm_sel;
  logic             wbm_we;
  logic             wbm_cyc;
  logic             wbm_stb;
  logic [DW-1:0]    wbm_dat_r;
  logic             wbm_ack;
  logic             wbm_err;
  logic [AW-1:0]    wbs_adr;
  logic [DW-1:0]    wbs_dat_w;
  logic [SW-1:0]    wbs_sel;
  logic             wbs_we;
  logic [NS-1:0]    wbs_cyc;
  logic [NS-1:0]    wbs_stb;
  logic [NS*DW-1:0] wbs_dat_r;
  logic [NS-1:0]    wbs_ack;

  logic [31:0] slv_data [NS];
  int checks = 0;
  int errors = 0;

  wb_intercon_n #(
    .NSLAVES    (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SEL_W      (SW),
    .SLAVE_MASK (MASKS),
    .SLAVE_ADDR (ADDRS),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wbm_adr_i (wbm_adr),
    .wbm_dat_i (wbm_dat_w),
    .wbm_sel_i (wbm_sel),
    .wbm_we_i  (wbm_we),
    .wbm_cyc_i (wbm_cyc),
    .wbm_stb_i (wbm_stb),
    .wbm_dat_o (wbm_dat_r),
    .wbm_ack_o (wbm_ack),
    .wbm_err_o (wbm_err),
    .wbs_adr_o (wbs_adr),
    .wbs_dat_o (wbs_dat_w),
    .wbs_sel_o (wbs_sel),
    .wbs_we_o  (wbs_we),
    .wbs_cyc_o (wbs_cyc),
    .wbs_stb_o (wbs_stb),
    .wbs_dat_i (wbs_dat_r),
    .wbs_ack_i (wbs_ack)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run stalls somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Step to 1 ns after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle;
    #1;
  endtask

  // Reference decode: the first matching slave in index order, or -1.
  function automatic int expectedSlave(input logic [31:0] a);
    for (int k = 0; k < NS; k++) begin
      if ((a & mask_tab[k]) == addr_tab[k]) return k;
    end
    return -1;
  endfunction

  // Give every slave new random read data.
  task automatic loadSlaveData;
    for (int k = 0; k < NS; k++) begin
      slv_data[k] = $urandom;
      wbs_dat_r[k*DW +: DW] = slv_data[k];
    end
  endtask

  // Run one master transaction and check every cycle of it.
  // ack_delay: ACTIVE cycles the slave waits before acking.
  //            Values of TO or more never ack.
  // rogue:     -1 none, -2 random other slave, else that slave acks while waiting.
  // abort_at / reset_at: ACTIVE cycle index at which the master drops cyc
  //                      or reset is raised; -1 disables each.
  task automatic applyStimulus(input logic [31:0] addr, input int ack_delay,
                               input int rogue, input int abort_at,
                               input int reset_at);
    int          tgt;
    int          other;
    logic [31:0] wdat;
    logic [3:0]  onehot;
    tgt    = expectedSlave(addr);
    wdat   = $urandom;
    onehot = (tgt >= 0) ? 4'(1 << tgt) : 4'h0;
    other  = -1;
    if (tgt >= 0 && rogue == -2) other = (tgt + 1 + int'($urandom_range(0, NS - 2))) % NS;
    else if (rogue >= 0)         other = rogue;
    loadSlaveData();
    wbs_ack   = '0;
    wbm_adr   = addr;
    wbm_dat_w = wdat;
    wbm_sel   = 4'($urandom);
    wbm_we    = 1'($urandom);
    wbm_cyc   = 1'b1;
    wbm_stb   = 1'b1;
    settle();
    checkOutput("bcast_adr", wbs_adr, addr);
    checkOutput("bcast_dat", wbs_dat_w, wdat);
    checkOutput("bcast_sel", wbs_sel, wbm_sel);
    checkOutput("bcast_we", wbs_we, wbm_we);
    checkOutput("idle_stb", wbs_stb, 0);
    checkOutput("idle_ack", wbm_ack, 0);
    tick();

    if (tgt < 0) begin
      checkOutput("unmapped_err", wbm_err, 1);
      checkOutput("unmapped_stb", wbs_stb, 0);
      checkOutput("unmapped_cyc", wbs_cyc, 0);
      checkOutput("unmapped_ack", wbm_ack, 0);
      wbm_cyc = 1'b0;
      wbm_stb = 1'b0;
      tick();
      checkOutput("unmapped_err_clr", wbm_err, 0);
      return;
    end

    for (int c = 0; c <= TO; c++) begin
      wbs_ack = '0;
      settle();
      if (c == TO) begin
        checkOutput("timeout_err", wbm_err, 1);
        checkOutput("timeout_stb", wbs_stb, 0);
        checkOutput("timeout_ack", wbm_ack, 0);
        wbm_cyc = 1'b0;
        wbm_stb = 1'b0;
        tick();
        checkOutput("timeout_err_clr", wbm_err, 0);
        return;
      end
      checkOutput("slave_stb", wbs_stb, onehot);
      checkOutput("slave_cyc", wbs_cyc, onehot);
      checkOutput("active_err", wbm_err, 0);
      if (c == reset_at) begin
        rst = 1'b1;
        tick();
        wbs_ack = onehot;
        settle();
        checkOutput("reset_cyc", wbs_cyc, 0);
        checkOutput("reset_stb", wbs_stb, 0);
        checkOutput("reset_ack", wbm_ack, 0);
        checkOutput("reset_err", wbm_err, 0);
        rst     = 1'b0;
        wbm_cyc = 1'b0;
        wbm_stb = 1'b0;
        wbs_ack = '0;
        tick();
        return;
      end
      if (c == abort_at) begin
        wbm_cyc = 1'b0;
        wbm_stb = 1'b0;
        settle();
        checkOutput("abort_cyc", wbs_cyc, 0);
        checkOutput("abort_stb", wbs_stb, 0);
        checkOutput("abort_ack", wbm_ack, 0);
        tick();
        checkOutput("abort_err", wbm_err, 0);
        return;
      end
      if (c == ack_delay) begin
        wbs_ack = onehot;
        settle();
        checkOutput("ack", wbm_ack, 1);
        checkOutput("ack_data", wbm_dat_r, slv_data[tgt]);
        checkOutput("ack_err", wbm_err, 0);
        tick();
        // Back in IDLE: the slave still holds ack and the master still
        // requests, yet nothing may reach either side this cycle.
        checkOutput("post_ack_stb", wbs_stb, 0);
        checkOutput("post_ack_ack", wbm_ack, 0);
        wbm_cyc = 1'b0;
        wbm_stb = 1'b0;
        wbs_ack = '0;
        return;
      end
      if (other >= 0) begin
        wbs_ack = 4'(1 << other);
        settle();
        checkOutput("rogue_ack", wbm_ack, 0);
      end
      checkOutput("wait_data", wbm_dat_r, slv_data[tgt]);
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    wbm_adr   = '0;
    wbm_dat_w = '0;
    wbm_sel   = '0;
    wbm_we    = 1'b0;
    wbm_cyc   = 1'b0;
    wbm_stb   = 1'b0;
    wbs_ack   = '0;
    loadSlaveData();
    repeat (2) tick();
    checkOutput("rst_cyc", wbs_cyc, 0);
    checkOutput("rst_stb", wbs_stb, 0);
    checkOutput("rst_ack", wbm_ack, 0);
    checkOutput("rst_err", wbm_err, 0);
    checkOutput("rst_dat", wbm_dat_r, 0);

    // A request held during reset must not start a transfer.
    wbm_cyc = 1'b1;
    wbm_stb = 1'b1;
    tick();
    checkOutput("rst_hold_stb", wbs_stb, 0);
    checkOutput("rst_hold_err", wbm_err, 0);
    rst     = 1'b0;
    wbm_cyc = 1'b0;
    wbm_stb = 1'b0;
    tick();

    // Directed scenarios.
    applyStimulus(32'h0000_0010, 2, -1, -1, -1);
    applyStimulus(32'h4000_0000, 1, -1, -1, -1);
    applyStimulus(32'h5000_0010, 0, -1, -1, -1);
    applyStimulus(32'h2000_0000, 0, -1, -1, -1);
    applyStimulus(32'h8000_0004, 99, -1, -1, -1);
    applyStimulus(32'h0000_0100, 3, 3, -1, -1);
    applyStimulus(32'h0000_0200, 99, -1, -1, 1);
    applyStimulus(32'h8000_0000, 99, -1, 1, -1);
    applyStimulus(32'h4000_0040, 0, -1, -1, -1);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      int          dly;
      int          rg;
      int          ab;
      int          rs;
      a   = {4'($urandom_range(0, 15)), 28'($urandom)};
      dly = int'($urandom_range(0, 5));
      rg  = ($urandom_range(0, 1) == 1) ? -2 : -1;
      ab  = -1;
      rs  = -1;
      case ($urandom_range(0, 9))
        0:       ab = int'($urandom_range(0, 2));
        1:       rs = int'($urandom_range(0, 2));
        default: ;
      endcase
      applyStimulus(a, dly, rg, ab, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
